// File: rtl/fsl_rx_pkg.sv
// Shared widths, assembler state encoding and FIFO entry layout
// for the FSL block receiver.
package fsl_rx_pkg;
    localparam int WORD_W = 32;
    localparam int BLK_W  = 128;
    localparam int WPB    = 4;

    typedef enum logic {
        FILL,
        HOLD
    } asm_state_t;

    typedef struct packed {
        logic              ctrl;
        logic [WORD_W-1:0] data;
    } fifo_entry_t;

    // Slot 0 is the most significant word of the block.
    function automatic int slot_lsb(logic [1:0] idx);
        return (WPB - 1 - int'(idx)) * WORD_W;
    endfunction
endpackage

// File: rtl/fsl_block_rx_if.sv
// FSL word stream in, assembled block out, as one bundle.
// The master modport is the traffic source/consumer side.
interface fsl_block_rx_if;
    import fsl_rx_pkg::*;

    logic              FSL_M_Write;
    logic [0:WORD_W-1] FSL_M_Data;
    logic              FSL_M_Control;
    logic              FSL_M_Full;
    logic [BLK_W-1:0]  blk_data;
    logic              blk_is_key;
    logic              blk_valid;
    logic              blk_ready;

    modport master (
        output FSL_M_Write, FSL_M_Data, FSL_M_Control, blk_ready,
        input  FSL_M_Full, blk_data, blk_is_key, blk_valid
    );

    modport slave (
        input  FSL_M_Write, FSL_M_Data, FSL_M_Control, blk_ready,
        output FSL_M_Full, blk_data, blk_is_key, blk_valid
    );
endinterface

// File: rtl/fsl_rx_fifo.sv
// Synchronous FIFO of {ctrl, data} entries; caller must not push
// when full or pop when empty.
module fsl_rx_fifo
    import fsl_rx_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  fifo_entry_t wdata,
    input  logic        pop,
    output fifo_entry_t rdata,
    output logic        full,
    output logic        empty
);
    localparam int AW = $clog2(DEPTH);

    fifo_entry_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/fsl_block_rx.sv
// Reassembles FSL words into 128-bit key/data blocks.
// Define FSL_RX_STATS_EN to add word_cnt/blk_cnt outputs.
module fsl_block_rx
    import fsl_rx_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             FSL_Clk,
    input  logic             FSL_Rst_n,
    fsl_block_rx_if.slave    bus,
    output logic             sync_err,
    output logic             ovf,
    output logic [CNT_W-1:0] err_cnt
`ifdef FSL_RX_STATS_EN
    ,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] blk_cnt
);
`else
);
`endif
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    fifo_entry_t wr_e;
    fifo_entry_t rd_e;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    asm_state_t  state;
    logic [1:0]  idx;

    assign push = bus.FSL_M_Write && !full;
    assign pop  = (state == FILL) && !empty;
    assign wr_e = '{ctrl: bus.FSL_M_Control, data: bus.FSL_M_Data};
    assign bus.FSL_M_Full = full;

    fsl_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (FSL_Clk),
        .rst_n (FSL_Rst_n),
        .push  (push),
        .wdata (wr_e),
        .pop   (pop),
        .rdata (rd_e),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge FSL_Clk or negedge FSL_Rst_n) begin
        if (!FSL_Rst_n) begin
            state          <= FILL;
            idx            <= '0;
            bus.blk_data   <= '0;
            bus.blk_is_key <= 1'b0;
            bus.blk_valid  <= 1'b0;
            sync_err       <= 1'b0;
            ovf            <= 1'b0;
            err_cnt        <= '0;
        end else begin
            sync_err <= 1'b0;
            if (bus.FSL_M_Write && full) ovf <= 1'b1;
            unique case (state)
                FILL: begin
                    if (pop) begin
                        // Control mid-block: restart as a key block at this word
                        if (rd_e.ctrl && idx != 2'd0) begin
                            bus.blk_data[BLK_W-1 -: WORD_W] <= rd_e.data;
                            bus.blk_is_key <= 1'b1;
                            idx            <= 2'd1;
                            sync_err       <= 1'b1;
                            if (err_cnt != CNT_MAX) err_cnt <= err_cnt + 1'b1;
                        end else begin
                            bus.blk_data[slot_lsb(idx) +: WORD_W] <= rd_e.data;
                            if (idx == 2'd0) bus.blk_is_key <= rd_e.ctrl;
                            idx <= idx + 2'd1;
                            if (idx == 2'd3) begin
                                state         <= HOLD;
                                bus.blk_valid <= 1'b1;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (bus.blk_ready) begin
                        state         <= FILL;
                        bus.blk_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef FSL_RX_STATS_EN
    always_ff @(posedge FSL_Clk or negedge FSL_Rst_n) begin
        if (!FSL_Rst_n) begin
            word_cnt <= '0;
            blk_cnt  <= '0;
        end else begin
            if (push && word_cnt != CNT_MAX) word_cnt <= word_cnt + 1'b1;
            if (bus.blk_valid && bus.blk_ready && blk_cnt != CNT_MAX)
                blk_cnt <= blk_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: doc/fsl_block_rx.md
Name: fsl_block_rx

Overview:
Receiving end of the FSL word stream produced by aes_accel's master port (FSL_M_*). Buffers incoming 32-bit words in a small FIFO and reassembles them into 128-bit blocks. The first word of each block lands in bits [127:96]. Presents each block on a valid/ready interface, tagged key/data by the FSL control bit. Sits between aes_accel and the downstream result consumer; FSL_M_Full provides the backpressure.

Parameters:
DEPTH, 8, FIFO depth in 32-bit words; power of two, >= 4
CNT_W, 16, width of error/statistics counters (saturating)

Ports:
FSL_Clk  in  1  single clock, all logic on rising edge
FSL_Rst_n  in  1  asynchronous active-low reset
FSL_M_Write  in  1  word strobe from the FSL master
FSL_M_Data  in  [0:31]  word; bit 0 is MSB
FSL_M_Control  in  1  marks first word of a key block
FSL_M_Full  out  1  backpressure to the master
blk_data  out  [127:0]  assembled block, word0 in [127:96]
blk_is_key  out  1  block began with Control=1
blk_valid  out  1  block available
blk_ready  in  1  consumer accepts block
sync_err  out  1  one-cycle pulse on misaligned Control
ovf  out  1  sticky: write attempted while full
err_cnt  out  CNT_W  saturating count of sync_err pulses

Behaviour:
- Reset values (async, FSL_Rst_n=0): FSL_M_Full=0, blk_data=0, blk_is_key=0, blk_valid=0, sync_err=0, ovf=0, err_cnt=0. FIFO empties, assembler returns to FILL with idx=0. Reset mid-block discards partial data.
- FIFO stores {Control, Data} (33 bits).
  - FSL_M_Full = (count == DEPTH), driven from registered count.
  - A write is accepted iff FSL_M_Write && !FSL_M_Full; the word is visible in the FIFO the next cycle.
  - FSL_M_Write while FSL_M_Full: word dropped, ovf set and held until reset.
  - Simultaneous push and pop: count unchanged. Pointers wrap modulo DEPTH.
- Assembler FSM, FILL(idx 0..3) -> HOLD -> FILL:
  - FILL: pops one word per cycle when FIFO is non-empty and writes it to slot idx (slot0 = [127:96]).
  - idx=0: blk_is_key is set from the popped Control bit.
  - idx 1..3 with Control=1 (misaligned): partial block discarded, sync_err pulses, err_cnt increments (saturating at all-ones). The word becomes slot0 of a new key block (idx=1 next).
  - Pop with idx=3 and Control=0: go to HOLD next cycle with blk_valid=1.
  - HOLD: no pops. blk_data and blk_is_key are stable while blk_valid=1. blk_valid && blk_ready -> FILL idx=0 next cycle, blk_valid=0.
- Latency: 4th word written at cycle N produces blk_valid at N+2 at the earliest. Throughput is 1 block per 5 cycles at full rate.
- Data words never carry Control=1 mid-block in legal traffic.

Optional Feature:
FSL_RX_STATS_EN
- Defined: adds outputs word_cnt [CNT_W-1:0] and blk_cnt [CNT_W-1:0].
  - word_cnt counts accepted writes; blk_cnt counts blk_valid&&blk_ready handshakes.
  - Both saturating, reset to 0.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package fsl_rx_pkg: FSL word width (32), block width (128), words-per-block (4), assembler state encoding (FILL, HOLD), FIFO entry typedef {ctrl, data}.
- Sub-module fsl_rx_fifo: parameterised DEPTH sync FIFO with count/full/empty. The assembler FSM stays in the top.

Test Plan:
- Key write B01DFACE_0DEC0DED_0BA11ADE_0EFFEC70 (Control=1 on first word only), blk_ready=1 -> one block: blk_is_key=1, blk_data=128'hB01DFACE0DEC0DED0BA11ADE0EFFEC70, blk_valid 2 cycles after 4th write.
- Data blocks 0, 00000001_00000002_00000003_00000004 and 00000002_00000003_00000004_00000005 back-to-back -> three blocks in order, blk_is_key=0, no sync_err.
- blk_ready=0, stream 12 words with DEPTH=8 -> FSL_M_Full asserts once count reaches 8. The master honouring Full causes no drops; forcing a write while Full sets ovf=1. Releasing ready drains the remaining blocks intact.
- Control=1 on the 3rd word of a block -> sync_err one-cycle pulse, err_cnt=1. The next block starts at that word and completes after 3 more words with blk_is_key=1.
- Random blk_ready (50%) over 300 data blocks -> every block matches the expected sequence, blk_data stable while valid&&!ready.
- FSL_Rst_n asserted after 2 words of a block, then released and a full block sent -> all outputs at reset values during reset; the first block after reset is exactly the 4 new words.
